shift_rows_pipe: RTL and testbench
==================================

# shift_rows_pipe

Registered, parametrised Rijndael ShiftRows / InvShiftRows stage with a valid/ready handshake and a two-entry skid buffer. It supports block widths of 128, 192 and 256 bits (Nb = 4, 6, 8 columns). The inverse operation is selected per beat, and a sideband tag travels with each beat. It sits between the SubBytes and MixColumns stages of the round pipeline and provides full-rate, fully backpressurable flow.

## Interface

Parameters:
- NB, default 4: state columns. Legal values are 4, 6 and 8; any other value is an elaboration error.
- TAG_W, default 4: sideband tag width (≥1).

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  stage can accept a beat
- in_state  input  [0:NB*32-1]  state, column-major: byte k = bits [8k:8k+7] = row k%4, column k/4
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows
- in_tag  input  [TAG_W-1:0]  opaque sideband
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts
- out_state  output  [0:NB*32-1]  transformed state
- out_inv  output  1  in_inv of this beat
- out_tag  output  [TAG_W-1:0]  in_tag of this beat

## Operation

- Row offsets: for NB = 4 and NB = 6, rows 0–3 use 0, 1, 2, 3. For NB = 8, they use 0, 1, 3, 4.
- Forward: out(r,c) = in(r, (c + s_r) mod NB).
- Inverse: out(r,c) = in(r, (c − s_r) mod NB).
- The transform is combinational on the input side. The result is captured, so beats are stored already transformed. It is a pure byte permutation with no arithmetic.
- Storage: main register (M, drives out_*) and skid register (S). Each holds state, inv, tag and a valid bit.
- in_ready = !S.valid, driven directly from the register.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready. out_valid = M.valid.
- Per-cycle update:
  - M empty, or M draining while S is empty: an accepted beat loads into M.
  - M full and not draining: an accepted beat loads into S.
  - M draining while S is full: S moves to M and S clears. No accept is possible because in_ready = 0.
  - Drain with no accept and S empty: M.valid clears.
- Occupancy states: EMPTY (M=0, S=0), ONE (M=1, S=0), FULL (M=1, S=1). S is never valid while M is invalid.
- Order is strictly FIFO. No beat is lost or duplicated. A stalled output holds out_state, out_inv and out_tag stable.
- in_state, in_inv and in_tag are sampled only on an accept. Their values in other cycles are don't-care.

## Timing

- Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N with out_valid = 1.
- Throughput: 1 beat per cycle while out_ready = 1.
- Reset: when rst is high at an edge, M.valid and S.valid go to 0, all data, inv and tag registers go to 0, and in_ready = 1 after that edge. After reset: out_valid = 0, out_state = 0, out_inv = 0, out_tag = 0, in_ready = 1.
- Any handshake in a cycle where rst = 1 is discarded. This holds mid-stream too: in-flight beats are dropped, not drained.
- Backpressure: with out_ready held low, exactly two beats are accepted. in_ready falls at the edge that fills S.
- Simultaneous accept and drain in state ONE stays in ONE, with the new beat in M. Accept and drain in FULL cannot occur.
- No combinational path from out_ready to in_ready.
- out_valid must not drop without a drain.

## Test plan

- NB=4 forward, bytes MSB-first: in_state = d42711aee0bf98f1b8b45de51e415230, inv=0 → one cycle later out_state = d4bf5d30e0b452aeb84111f11e2798e5, out_valid = 1.
- NB=4 inverse: in_state = d4bf5d30e0b452aeb84111f11e2798e5, inv=1, tag=5 → out_state = d42711aee0bf98f1b8b45de51e415230, out_inv = 1, out_tag = 5.
- NB=6 and NB=8 forward, in byte k = k:
  - NB=6: first column 00 05 0a 0f, last column 14 01 06 0b.
  - NB=8: first column 00 05 0e 13, last column 1c 01 0a 0f.
  - Inverse of each output restores the input.
- Backpressure: out_ready = 0, send tags 1, 2, 3 back-to-back. Tags 1 and 2 are accepted and in_ready = 0 after the second. Tag 3 is held at the input. Raising out_ready produces tags 1, 2, 3 on consecutive cycles with no gaps.
- Streaming: 100 random beats with random in_valid and out_ready (mixed NB-legal inv). Scoreboard matches every beat in order, with zero loss. out_* stay stable while stalled.
- Reset mid-operation: in state FULL, assert rst for 1 cycle with in_valid = 1 → out_valid = 0, out_state = 0, in_ready = 1. The beat presented during rst never appears, and the next accepted beat emerges after 1 cycle.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: registered ShiftRows/InvShiftRows stage with valid/ready handshake and two-entry skid buffer
module shift_rows_pipe #(
  parameter int NB = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:NB*32-1]   in_state,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:NB*32-1]   out_state,
  output logic               out_inv,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int W = NB * 32;
  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  logic [0:W-1]     fwd_st, inv_st, tr_st;
  logic             accept, drain;
  logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [0:W-1]     m_state_q, m_state_d, s_state_q, s_state_d;
  logic             m_inv_q, m_inv_d, s_inv_q, s_inv_d;
  logic [TAG_W-1:0] m_tag_q, m_tag_d, s_tag_q, s_tag_d;
  // byte (r,c) of the result picks byte (r, c +/- row offset) of the input; NB=8 skips offset 2
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int sh = (NB == 8 && r >= 2) ? r + 1 : r;
      assign fwd_st[8*(4*c+r) +: 8] = in_state[8*(4*((c+sh)%NB)+r) +: 8];
      assign inv_st[8*(4*c+r) +: 8] = in_state[8*(4*((c+NB-sh)%NB)+r) +: 8];
    end
  end
  assign tr_st     = in_inv ? inv_st : fwd_st;
  assign in_ready  = !s_valid_q;
  assign accept    = in_valid & in_ready;
  assign drain     = m_valid_q & out_ready;
  assign out_valid = m_valid_q;
  assign out_state = m_state_q;
  assign out_inv   = m_inv_q;
  assign out_tag   = m_tag_q;
  // occupancy update: new beats go to M when it is free or freeing with S empty, otherwise to S; S refills M on drain
  always_comb begin
    m_valid_d = m_valid_q;
    m_state_d = m_state_q;
    m_inv_d   = m_inv_q;
    m_tag_d   = m_tag_q;
    s_valid_d = s_valid_q;
    s_state_d = s_state_q;
    s_inv_d   = s_inv_q;
    s_tag_d   = s_tag_q;
    if (!m_valid_q || (drain && !s_valid_q)) begin
      m_valid_d = accept;
      m_state_d = accept ? tr_st : m_state_q;
      m_inv_d   = accept ? in_inv : m_inv_q;
      m_tag_d   = accept ? in_tag : m_tag_q;
    end else if (drain) begin
      m_state_d = s_state_q;
      m_inv_d   = s_inv_q;
      m_tag_d   = s_tag_q;
      s_valid_d = 1'b0;
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_state_d = tr_st;
      s_inv_d   = in_inv;
      s_tag_d   = in_tag;
    end
  end
  // main and skid registers, cleared entirely on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_state_q <= '0;
      m_inv_q   <= 1'b0;
      m_tag_q   <= '0;
      s_valid_q <= 1'b0;
      s_state_q <= '0;
      s_inv_q   <= 1'b0;
      s_tag_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_state_q <= m_state_d;
      m_inv_q   <= m_inv_d;
      m_tag_q   <= m_tag_d;
      s_valid_q <= s_valid_d;
      s_state_q <= s_state_d;
      s_inv_q   <= s_inv_d;
      s_tag_q   <= s_tag_d;
    end
  end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: randomized and directed checks of shift_rows_pipe for NB = 4, 6, 8 against a queue model
module tb_shift_rows_pipe;
  logic clk = 1'b0, rst, in_valid, in_inv, out_ready;
  logic [3:0] in_tag;
  logic [0:255] in_st;
  logic in_ready4, in_ready6, in_ready8, out_valid4, out_valid6, out_valid8;
  logic out_inv4, out_inv6, out_inv8;
  logic [3:0] out_tag4, out_tag6, out_tag8;
  logic [0:127] out4;
  logic [0:191] out6;
  logic [0:255] out8;
  int checks = 0, errors = 0, n_acc = 0;
  typedef struct {
    logic [0:255] e4, e6, e8;
    logic inv;
    logic [3:0] tag;
  } entry_t;
  entry_t q[$];
  always #5 clk = ~clk;
  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_state(in_st[0:127]), .in_inv(in_inv), .in_tag(in_tag), .out_valid(out_valid4), .out_ready(out_ready),
    .out_state(out4), .out_inv(out_inv4), .out_tag(out_tag4));
  shift_rows_pipe #(.NB(6), .TAG_W(4)) dut6 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6),
    .in_state(in_st[0:191]), .in_inv(in_inv), .in_tag(in_tag), .out_valid(out_valid6), .out_ready(out_ready),
    .out_state(out6), .out_inv(out_inv6), .out_tag(out_tag6));
  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_state(in_st), .in_inv(in_inv), .in_tag(in_tag), .out_valid(out_valid8), .out_ready(out_ready),
    .out_state(out8), .out_inv(out_inv8), .out_tag(out_tag8));
  task automatic chk(input string n, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, got, exp);
    end
  endtask
  function automatic logic [0:255] ref_sr(input int nb, input logic [0:255] st, input bit inv);
    logic [0:255] o = '0;
    for (int r = 0; r < 4; r++) begin
      int s = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        int src = inv ? (c - s + nb) % nb : (c + s) % nb;
        o[8*(4*c+r) +: 8] = st[8*(4*src+r) +: 8];
      end
    end
    return o;
  endfunction
  function automatic logic [0:255] rnd256();
    logic [0:255] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction
  task automatic check_outs();
    bit rdy = q.size() < 2, vld = q.size() > 0;
    chk("in_ready", {in_ready4, in_ready6, in_ready8}, {rdy, rdy, rdy});
    chk("out_valid", {out_valid4, out_valid6, out_valid8}, {vld, vld, vld});
    if (vld) begin
      chk("state4", out4, q[0].e4[0:127]);
      chk("state6", out6, q[0].e6[0:191]);
      chk("state8", out8, q[0].e8);
      chk("inv_tag", {out_inv4, out_inv6, out_inv8, out_tag4, out_tag6, out_tag8},
          {q[0].inv, q[0].inv, q[0].inv, q[0].tag, q[0].tag, q[0].tag});
    end
  endtask
  task automatic step(input bit v, input bit iv, input logic [3:0] tg, input logic [0:255] st, input bit ordy, input bit r);
    entry_t e;
    bit acc, drn;
    in_valid = v; in_inv = iv; in_tag = tg; in_st = st; out_ready = ordy; rst = r;
    e.e4 = ref_sr(4, st, iv); e.e6 = ref_sr(6, st, iv); e.e8 = ref_sr(8, st, iv); e.inv = iv; e.tag = tg;
    @(posedge clk);
    acc = !r && v && q.size() < 2;
    drn = !r && ordy && q.size() > 0;
    if (r) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) begin q.push_back(e); n_acc++; end
    end
    #1 check_outs();
  endtask
  initial begin
    logic [0:255] v, orig, o6, o8;
    int cyc;
    #2;
    step(0, 0, 0, '0, 0, 1);
    chk("rst_zero", {out4, out_inv4, out_tag4}, '0);
    step(0, 0, 0, '0, 1, 0);
    v = '0; v[0:127] = 128'hd42711aee0bf98f1b8b45de51e415230;
    step(1, 0, 0, v, 1, 0);
    chk("aes_fwd", out4, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    v[0:127] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    step(1, 1, 5, v, 1, 0);
    chk("aes_inv", out4, 128'hd42711aee0bf98f1b8b45de51e415230);
    chk("aes_inv_tag", {out_inv4, out_tag4}, {1'b1, 4'd5});
    for (int k = 0; k < 32; k++) orig[8*k +: 8] = 8'(k);
    step(1, 0, 0, orig, 1, 0);
    chk("nb6_first", out6[0:31], 32'h00050a0f);
    chk("nb6_last", out6[160:191], 32'h1401060b);
    chk("nb8_first", out8[0:31], 32'h00050e13);
    chk("nb8_last", out8[224:255], 32'h1c010a0f);
    o6 = '0; o6[0:191] = out6; o8 = out8;
    step(1, 1, 0, o6, 1, 0);
    chk("nb6_inv", out6, orig[0:191]);
    step(1, 1, 0, o8, 1, 0);
    chk("nb8_inv", out8, orig);
    step(0, 0, 0, '0, 1, 0);
    step(1, 0, 1, rnd256(), 0, 0);
    step(1, 0, 2, rnd256(), 0, 0);
    chk("bp_ready_low", in_ready4, 1'b0);
    step(1, 0, 3, rnd256(), 0, 0);
    step(1, 0, 3, rnd256(), 0, 0);
    chk("bp_hold1", out_tag4, 4'd1);
    step(1, 0, 3, rnd256(), 1, 0);
    chk("bp_seq2", {out_valid4, out_tag4}, {1'b1, 4'd2});
    step(1, 0, 3, rnd256(), 1, 0);
    chk("bp_seq3", {out_valid4, out_tag4}, {1'b1, 4'd3});
    step(0, 0, 0, '0, 1, 0);
    chk("bp_empty", out_valid4, 1'b0);
    n_acc = 0;
    cyc = 0;
    while (n_acc < 100 && cyc < 3000) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), rnd256(), 1'($urandom_range(0, 2) != 0), 0);
      cyc++;
    end
    chk("stream_count", 256'(n_acc), 256'd100);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, 0);
    step(1, 0, 4, rnd256(), 0, 0);
    step(1, 1, 6, rnd256(), 0, 0);
    chk("full_ready", in_ready4, 1'b0);
    step(1, 0, 9, rnd256(), 0, 1);
    chk("mid_rst", {out_valid4, in_ready4, out_inv4, out_tag4}, {1'b0, 1'b1, 1'b0, 4'd0});
    chk("mid_rst_state", {out4, out8}, '0);
    step(1, 1, 7, rnd256(), 1, 0);
    chk("post_rst", {out_valid4, out_tag4}, {1'b1, 4'd7});
    step(0, 0, 0, '0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
